// File: rtl/ps2_kbd_ctrl.sv
// ps2_kbd_ctrl -- PS/2 keyboard receiver with scan-code decoding and key FIFO.
//
// Receives 11-bit PS/2 frames (start, 8 data LSB first, parity, stop),
// folds the E0 (extended) and F0 (break) prefixes into the stored entry,
// suppresses release events and queues make codes in a small FIFO.
//
// Ports:
//   clk, rst      system clock (rising edge), asynchronous active-high reset
//   ps2_clk/data  raw keyboard lines, asynchronous to clk
//   pop           consumer strobe, removes the FIFO head
//   key_code      head scan code, key_ext: head had an E0 prefix
//   key_valid     FIFO not empty
//   frame_err     one-cycle pulse on a rejected or timed-out frame
//   ovf / ovf_clr sticky overflow flag and its synchronous clear
//
// Build option: define PS2_PARITY_CHK_EN to reject frames with bad odd parity.

module ps2_kbd_ctrl #(
    parameter int FIFO_DEPTH  = 4,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       pop,
    output logic [7:0] key_code,
    output logic       key_ext,
    output logic       key_valid,
    output logic       frame_err,
    output logic       ovf,
    input  logic       ovf_clr
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {IDLE, RECV, CHECK} state_t;

    state_t          state_q, state_d;
    logic [1:0]      ps2_clk_sync_q, ps2_clk_sync_d;
    logic [1:0]      ps2_data_sync_q, ps2_data_sync_d;
    logic            ps2_clk_prev_q, ps2_clk_prev_d;
    logic [3:0]      bit_cnt_q, bit_cnt_d;
    logic [9:0]      shift_q, shift_d;
    logic [TW-1:0]   to_cnt_q, to_cnt_d;
    logic            ext_pend_q, ext_pend_d;
    logic            brk_pend_q, brk_pend_d;
    logic            frame_err_q, frame_err_d;
    logic            ovf_q, ovf_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [8:0]      mem_q [FIFO_DEPTH];
    logic [8:0]      mem_d [FIFO_DEPTH];

    logic fall;
    logic data_bit;
    logic parity_ok;
    logic frame_ok;
    logic byte_ok;
    logic push_req;
    logic pop_en;
    logic full;
    logic wr_en;

    // Synchronizer stages; the previous synchronized clock gives edge detection.
    always_comb begin
        ps2_clk_sync_d  = {ps2_clk_sync_q[0], ps2_clk};
        ps2_data_sync_d = {ps2_data_sync_q[0], ps2_data};
        ps2_clk_prev_d  = ps2_clk_sync_q[1];
    end

    assign fall     = ps2_clk_prev_q & ~ps2_clk_sync_q[1];
    assign data_bit = ps2_data_sync_q[1];

    // After ten shifts: [7:0] data, [8] parity, [9] stop.
`ifdef PS2_PARITY_CHK_EN
    assign parity_ok = ^shift_q[8:0];
`else
    assign parity_ok = 1'b1;
`endif
    assign frame_ok = shift_q[9] & parity_ok;

    // Frame reception FSM with inter-edge timeout.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        to_cnt_d    = to_cnt_q;
        frame_err_d = 1'b0;
        byte_ok     = 1'b0;
        case (state_q)
            IDLE: begin
                to_cnt_d = '0;
                if (fall && !data_bit) begin
                    state_d   = RECV;
                    bit_cnt_d = 4'd0;
                end
            end
            RECV: begin
                if (fall) begin
                    shift_d  = {data_bit, shift_q[9:1]};
                    to_cnt_d = '0;
                    if (bit_cnt_q == 4'd9) begin
                        state_d   = CHECK;
                        bit_cnt_d = 4'd0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end else if (to_cnt_q == TW'(TIMEOUT_CYC - 1)) begin
                    state_d     = IDLE;
                    frame_err_d = 1'b1;
                    to_cnt_d    = '0;
                    bit_cnt_d   = 4'd0;
                end else begin
                    to_cnt_d = to_cnt_q + TW'(1);
                end
            end
            CHECK: begin
                state_d = IDLE;
                if (frame_ok) begin
                    byte_ok = 1'b1;
                end else begin
                    frame_err_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Prefix tracking: E0 marks extended, F0 swallows the next code (release).
    always_comb begin
        ext_pend_d = ext_pend_q;
        brk_pend_d = brk_pend_q;
        push_req   = 1'b0;
        if (byte_ok) begin
            if (shift_q[7:0] == 8'hE0) begin
                ext_pend_d = 1'b1;
            end else if (shift_q[7:0] == 8'hF0) begin
                brk_pend_d = 1'b1;
            end else if (brk_pend_q) begin
                brk_pend_d = 1'b0;
                ext_pend_d = 1'b0;
            end else begin
                push_req   = 1'b1;
                ext_pend_d = 1'b0;
            end
        end
    end

    // FIFO: a pop in the same cycle frees room for a push into a full FIFO.
    always_comb begin
        pop_en   = pop && (count_q != '0);
        full     = (count_q == CW'(FIFO_DEPTH));
        wr_en    = push_req && (!full || pop_en);
        mem_d    = mem_q;
        if (wr_en) begin
            mem_d[wr_ptr_q] = {ext_pend_q, shift_q[7:0]};
        end
        wr_ptr_d = wr_ptr_q + AW'(wr_en);
        rd_ptr_d = rd_ptr_q + AW'(pop_en);
        count_d  = count_q + CW'(wr_en) - CW'(pop_en);
        ovf_d    = ovf_q;
        if (ovf_clr) begin
            ovf_d = 1'b0;
        end
        if (push_req && full && !pop_en) begin
            ovf_d = 1'b1;
        end
    end

    // State registers; idle-high synchronizer reset avoids a false edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= IDLE;
            ps2_clk_sync_q  <= 2'b11;
            ps2_data_sync_q <= 2'b11;
            ps2_clk_prev_q  <= 1'b1;
            bit_cnt_q       <= 4'd0;
            shift_q         <= '0;
            to_cnt_q        <= '0;
            ext_pend_q      <= 1'b0;
            brk_pend_q      <= 1'b0;
            frame_err_q     <= 1'b0;
            ovf_q           <= 1'b0;
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            count_q         <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q         <= state_d;
            ps2_clk_sync_q  <= ps2_clk_sync_d;
            ps2_data_sync_q <= ps2_data_sync_d;
            ps2_clk_prev_q  <= ps2_clk_prev_d;
            bit_cnt_q       <= bit_cnt_d;
            shift_q         <= shift_d;
            to_cnt_q        <= to_cnt_d;
            ext_pend_q      <= ext_pend_d;
            brk_pend_q      <= brk_pend_d;
            frame_err_q     <= frame_err_d;
            ovf_q           <= ovf_d;
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            count_q         <= count_d;
            mem_q           <= mem_d;
        end
    end

    assign key_code  = mem_q[rd_ptr_q][7:0];
    assign key_ext   = mem_q[rd_ptr_q][8];
    assign key_valid = (count_q != '0);
    assign frame_err = frame_err_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// tb_ps2_kbd_ctrl -- self-checking bench for ps2_kbd_ctrl.
// Frames are bit-banged on ps2_clk/ps2_data; expected FIFO entries are
// queued when a frame is sent and compared as the consumer pops them.

module tb_ps2_kbd_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       ps2_clk;
    logic       ps2_data;
    logic       pop;
    logic       ovf_clr;
    logic [7:0] key_code;
    logic       key_ext;
    logic       key_valid;
    logic       frame_err;
    logic       ovf;

    int         nCompared   = 0;
    int         nMismatched = 0;
    int         errCnt      = 0;
    int         errBefore;
    logic [8:0] expQ [$];

    typedef struct {
        logic [7:0] code;
        logic       flipPar;
        logic       badStop;
        logic       expPush;
        logic       expExt;
        int         expErr;
    } vec_t;

    vec_t vecs [14];

    ps2_kbd_ctrl #(.FIFO_DEPTH(4), .TIMEOUT_CYC(4096)) dut (
        .clk       (clk),
        .rst       (rst),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .pop       (pop),
        .key_code  (key_code),
        .key_ext   (key_ext),
        .key_valid (key_valid),
        .frame_err (frame_err),
        .ovf       (ovf),
        .ovf_clr   (ovf_clr)
    );

    // 100 MHz system clock.
    always #5 clk = ~clk;

    // Count every cycle frame_err is high; a clean pulse adds exactly one.
    always @(negedge clk) begin
        if (frame_err) errCnt++;
    end

    // Hard stop in case something stalls the main sequence.
    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        nCompared++;
        if (actual !== expected) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic sendBit(input logic b);
        @(negedge clk);
        ps2_data = b;
        repeat (4) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (8) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic applyStimulus(input logic [7:0] code, input logic flipPar,
                                 input logic badStop);
        logic par;
        par = (~^code) ^ flipPar;
        sendBit(1'b0);
        for (int i = 0; i < 8; i++) sendBit(code[i]);
        sendBit(par);
        sendBit(~badStop);
        ps2_data = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic drainCheck(input string tag);
        logic [8:0] e;
        checkOutput({tag, " key_valid"}, key_valid, expQ.size() != 0);
        for (int k = 0; k < 8 && expQ.size() > 0; k++) begin
            e = expQ.pop_front();
            checkOutput({tag, " head_valid"}, key_valid, 1);
            checkOutput({tag, " key_code"}, key_code, e[7:0]);
            checkOutput({tag, " key_ext"}, key_ext, e[8]);
            pop = 1'b1;
            @(negedge clk);
            pop = 1'b0;
        end
        checkOutput({tag, " empty"}, key_valid, 0);
    endtask

    initial begin
        vecs[0]  = '{8'h79, 1'b0, 1'b0, 1'b1, 1'b0, 0};
        vecs[1]  = '{8'hF0, 1'b0, 1'b0, 1'b0, 1'b0, 0};
        vecs[2]  = '{8'h79, 1'b0, 1'b0, 1'b0, 1'b0, 0};
        vecs[3]  = '{8'hE0, 1'b0, 1'b0, 1'b0, 1'b0, 0};
        vecs[4]  = '{8'h75, 1'b0, 1'b0, 1'b1, 1'b1, 0};
        vecs[5]  = '{8'hE0, 1'b0, 1'b0, 1'b0, 1'b0, 0};
        vecs[6]  = '{8'hF0, 1'b0, 1'b0, 1'b0, 1'b0, 0};
        vecs[7]  = '{8'h75, 1'b0, 1'b0, 1'b0, 1'b0, 0};
        vecs[8]  = '{8'h1C, 1'b0, 1'b0, 1'b1, 1'b0, 0};
`ifdef PS2_PARITY_CHK_EN
        vecs[9]  = '{8'h69, 1'b1, 1'b0, 1'b0, 1'b0, 1};
`else
        vecs[9]  = '{8'h69, 1'b1, 1'b0, 1'b1, 1'b0, 0};
`endif
        vecs[10] = '{8'hE0, 1'b0, 1'b0, 1'b0, 1'b0, 0};
        vecs[11] = '{8'h69, 1'b0, 1'b1, 1'b0, 1'b0, 1};
        vecs[12] = '{8'h6B, 1'b0, 1'b0, 1'b1, 1'b1, 0};
        vecs[13] = '{8'hFF, 1'b0, 1'b0, 1'b1, 1'b0, 0};

        rst      = 1'b0;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        pop      = 1'b0;
        ovf_clr  = 1'b0;
        #1 rst = 1'b1;
        #2;
        checkOutput("reset key_valid", key_valid, 0);
        checkOutput("reset key_code", key_code, 0);
        checkOutput("reset key_ext", key_ext, 0);
        checkOutput("reset frame_err", frame_err, 0);
        checkOutput("reset ovf", ovf, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Table of single frames, drained after each one.
        for (int i = 0; i < 14; i++) begin
            errBefore = errCnt;
            if (vecs[i].expPush) expQ.push_back({vecs[i].expExt, vecs[i].code});
            applyStimulus(vecs[i].code, vecs[i].flipPar, vecs[i].badStop);
            checkOutput($sformatf("vec%0d frame_err", i), errCnt - errBefore, vecs[i].expErr);
            drainCheck($sformatf("vec%0d", i));
        end

        // Partial frame followed by a long idle must time out.
        errBefore = errCnt;
        sendBit(1'b0);
        for (int i = 0; i < 4; i++) sendBit(i[0]);
        repeat (4200) @(negedge clk);
        checkOutput("timeout frame_err", errCnt - errBefore, 1);
        errBefore = errCnt;
        expQ.push_back({1'b0, 8'h74});
        applyStimulus(8'h74, 1'b0, 1'b0);
        checkOutput("post-timeout frame_err", errCnt - errBefore, 0);
        drainCheck("post-timeout");

        // Five make codes into a four-entry FIFO.
        for (int i = 0; i < 5; i++) begin
            logic [7:0] c;
            c = 8'h16 + 8'(i * 8);
            if (i < 4) expQ.push_back({1'b0, c});
            applyStimulus(c, 1'b0, 1'b0);
        end
        checkOutput("overflow ovf", ovf, 1);
        drainCheck("overflow");
        checkOutput("ovf sticky", ovf, 1);
        @(negedge clk);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        checkOutput("ovf_clr", ovf, 0);

        // Reset in the middle of a frame with a full FIFO and ovf set.
        for (int i = 0; i < 5; i++) applyStimulus(8'h2C, 1'b0, 1'b0);
        checkOutput("pre-reset ovf", ovf, 1);
        checkOutput("pre-reset key_code", key_code, 8'h2C);
        sendBit(1'b0);
        for (int i = 0; i < 4; i++) sendBit(8'h5A >> i);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checkOutput("midframe reset key_valid", key_valid, 0);
        checkOutput("midframe reset key_code", key_code, 0);
        checkOutput("midframe reset key_ext", key_ext, 0);
        checkOutput("midframe reset frame_err", frame_err, 0);
        checkOutput("midframe reset ovf", ovf, 0);
        expQ.delete();
        ps2_data = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        errBefore = errCnt;
        expQ.push_back({1'b0, 8'h5A});
        applyStimulus(8'h5A, 1'b0, 1'b0);
        checkOutput("post-reset frame_err", errCnt - errBefore, 0);
        drainCheck("post-reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
